// File: rtl/wb_buf_stage.sv
// Write-back stage: formats load results, queues them in order, drains to the RF write port.
// Optional WB_FWD_EN adds a youngest-first forwarding search over pending buffered writes.
module wb_buf_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  output logic                         o_wb_ready,
  input  logic [RF_ADDR_W-1:0]         i_rd_addr,
  input  logic                         i_rd_we,
  input  logic                         i_mem_to_reg,
  input  logic [XLEN-1:0]              i_alu_data,
  input  logic [XLEN-1:0]              i_mem_data,
  input  logic [1:0]                   i_ld_size,
  input  logic                         i_ld_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]    i_byte_off,
  input  logic                         i_staller,
  input  logic                         i_rf_grant,
  output logic [RF_ADDR_W-1:0]         o_wb_wr_reg_addr,
  output logic [XLEN-1:0]              o_wb_wr_reg_data,
  output logic                         o_wb_wr_reg_en,
  output logic                         o_unstall
`ifdef WB_FWD_EN
  ,
  input  logic [RF_ADDR_W-1:0]         i_fwd_addr,
  output logic                         o_fwd_hit,
  output logic [XLEN-1:0]              o_fwd_data
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [RF_ADDR_W-1:0] mem_addr  [BUF_DEPTH];
  logic                 mem_we    [BUF_DEPTH];
  logic [XLEN-1:0]      mem_data  [BUF_DEPTH];
  logic                 mem_stall [BUF_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic            push;
  logic            pop;
  logic            not_empty;
  logic [XLEN-1:0] sh;
  logic            sign_b;
  logic            sign_h;
  logic            sign_w;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] wr_data;
  logic            wr_we;

  assign not_empty  = (count != '0);
  assign o_wb_ready = (count < CNT_W'(BUF_DEPTH));
  assign push       = i_valid & o_wb_ready;
  assign pop        = not_empty & i_rf_grant;

  assign sh     = i_mem_data >> {i_byte_off, 3'b000};
  assign sign_b = ~i_ld_unsigned & sh[7];
  assign sign_h = ~i_ld_unsigned & sh[15];
  assign sign_w = ~i_ld_unsigned & sh[31];

  // Fill with the sign first, then overlay the loaded field; avoids zero-width
  // replications when XLEN is 32.
  always_comb begin
    ld_fmt = i_mem_data;
    case (i_ld_size)
      2'b00: begin
        ld_fmt      = {XLEN{sign_b}};
        ld_fmt[7:0] = sh[7:0];
      end
      2'b01: begin
        ld_fmt       = {XLEN{sign_h}};
        ld_fmt[15:0] = sh[15:0];
      end
      2'b10: begin
        ld_fmt       = {XLEN{sign_w}};
        ld_fmt[31:0] = sh[31:0];
      end
      default: ld_fmt = i_mem_data;
    endcase
  end

  assign wr_data = i_mem_to_reg ? ld_fmt : i_alu_data;
  assign wr_we   = i_rd_we & (i_rd_addr != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= i_rd_addr;
      mem_we[wr_ptr]    <= wr_we;
      mem_data[wr_ptr]  <= wr_data;
      mem_stall[wr_ptr] <= i_staller;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_unstall <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      o_unstall <= pop & mem_stall[rd_ptr];
    end
  end

  assign o_wb_wr_reg_en   = pop & mem_we[rd_ptr];
  assign o_wb_wr_reg_addr = not_empty ? mem_addr[rd_ptr] : '0;
  assign o_wb_wr_reg_data = not_empty ? mem_data[rd_ptr] : '0;

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    fwd_idx    = rd_ptr;
    if (i_fwd_addr != '0) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fwd_idx = rd_ptr + PTR_W'(i);
        if ((CNT_W'(i) < count) && mem_we[fwd_idx] && (mem_addr[fwd_idx] == i_fwd_addr)) begin
          o_fwd_hit  = 1'b1;
          o_fwd_data = mem_data[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_buf_stage.sv
// Directed self-checking bench for wb_buf_stage (default parameters, XLEN=32, depth 2).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wb_buf_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_wb_ready;
  logic [4:0]  i_rd_addr;
  logic        i_rd_we;
  logic        i_mem_to_reg;
  logic [31:0] i_alu_data;
  logic [31:0] i_mem_data;
  logic [1:0]  i_ld_size;
  logic        i_ld_unsigned;
  logic [1:0]  i_byte_off;
  logic        i_staller;
  logic        i_rf_grant;
  logic [4:0]  o_wb_wr_reg_addr;
  logic [31:0] o_wb_wr_reg_data;
  logic        o_wb_wr_reg_en;
  logic        o_unstall;
`ifdef WB_FWD_EN
  logic [4:0]  i_fwd_addr;
  logic        o_fwd_hit;
  logic [31:0] o_fwd_data;
`endif

  int n_assert;
  int n_fail;

  wb_buf_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_valid          (i_valid),
    .o_wb_ready       (o_wb_ready),
    .i_rd_addr        (i_rd_addr),
    .i_rd_we          (i_rd_we),
    .i_mem_to_reg     (i_mem_to_reg),
    .i_alu_data       (i_alu_data),
    .i_mem_data       (i_mem_data),
    .i_ld_size        (i_ld_size),
    .i_ld_unsigned    (i_ld_unsigned),
    .i_byte_off       (i_byte_off),
    .i_staller        (i_staller),
    .i_rf_grant       (i_rf_grant),
    .o_wb_wr_reg_addr (o_wb_wr_reg_addr),
    .o_wb_wr_reg_data (o_wb_wr_reg_data),
    .o_wb_wr_reg_en   (o_wb_wr_reg_en),
    .o_unstall        (o_unstall)
`ifdef WB_FWD_EN
    ,
    .i_fwd_addr       (i_fwd_addr),
    .o_fwd_hit        (o_fwd_hit),
    .o_fwd_data       (o_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] mem,
                          input logic [1:0] size, input logic uns, input logic [1:0] off);
    i_valid       = 1'b1;
    i_rd_addr     = rd;
    i_rd_we       = 1'b1;
    i_mem_to_reg  = 1'b1;
    i_mem_data    = mem;
    i_ld_size     = size;
    i_ld_unsigned = uns;
    i_byte_off    = off;
    i_staller     = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] val, input logic stall);
    i_valid      = 1'b1;
    i_rd_addr    = rd;
    i_rd_we      = 1'b1;
    i_mem_to_reg = 1'b0;
    i_alu_data   = val;
    i_staller    = stall;
  endtask

  initial begin
    int  np;
    int  nw;
    int  cnt;
    logic pushing;
    logic popping;

    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    i_valid = 1'b0; i_rd_addr = '0; i_rd_we = 1'b0; i_mem_to_reg = 1'b0;
    i_alu_data = '0; i_mem_data = '0; i_ld_size = '0; i_ld_unsigned = 1'b0;
    i_byte_off = '0; i_staller = 1'b0; i_rf_grant = 1'b0;
`ifdef WB_FWD_EN
    i_fwd_addr = '0;
`endif

    // reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i_rf_grant = 1'b1;
    #1;
    chk("rst_ready", o_wb_ready, 1);
    chk("rst_en", o_wb_wr_reg_en, 0);
    chk("rst_unstall", o_unstall, 0);
    chk("rst_data", o_wb_wr_reg_data, 0);
    chk("rst_addr", o_wb_wr_reg_addr, 0);

    // lb signed, offset 3
    @(negedge clk);
    set_load(5'd5, 32'h80FF7F00, 2'b00, 1'b0, 2'd3);
    #1;
    chk("lb_pre_en", o_wb_wr_reg_en, 0);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("lb_s_en", o_wb_wr_reg_en, 1);
    chk("lb_s_addr", o_wb_wr_reg_addr, 5);
    chk("lb_s_data", o_wb_wr_reg_data, 32'hFFFFFF80);

    // lbu
    @(negedge clk);
    set_load(5'd5, 32'h80FF7F00, 2'b00, 1'b1, 2'd3);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("lbu_en", o_wb_wr_reg_en, 1);
    chk("lbu_data", o_wb_wr_reg_data, 32'h00000080);

    // lh offset 2
    @(negedge clk);
    set_load(5'd6, 32'h80FF7F00, 2'b01, 1'b0, 2'd2);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("lh_addr", o_wb_wr_reg_addr, 6);
    chk("lh_data", o_wb_wr_reg_data, 32'hFFFF80FF);

    // lhu offset 1 -> bytes 0xFF7F
    @(negedge clk);
    set_load(5'd6, 32'h80FF7F00, 2'b01, 1'b1, 2'd1);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("lhu_data", o_wb_wr_reg_data, 32'h0000FF7F);

    // lw
    @(negedge clk);
    set_load(5'd9, 32'h80FF7F00, 2'b10, 1'b0, 2'd0);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("lw_data", o_wb_wr_reg_data, 32'h80FF7F00);
    chk("lw_unstall", o_unstall, 0);

    // backpressure: fill with grant low, then drain in order
    @(negedge clk);
    i_rf_grant = 1'b0;
    set_alu(5'd1, 32'h11, 1'b0);
    @(negedge clk);
    set_alu(5'd2, 32'h22, 1'b0);
    #1;
    chk("fill_ready1", o_wb_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("full_ready", o_wb_ready, 0);
    chk("full_en", o_wb_wr_reg_en, 0);
    chk("full_head_addr", o_wb_wr_reg_addr, 1);
    @(negedge clk);
    i_rf_grant = 1'b1;
    #1;
    chk("drain1_en", o_wb_wr_reg_en, 1);
    chk("drain1_addr", o_wb_wr_reg_addr, 1);
    chk("drain1_data", o_wb_wr_reg_data, 32'h11);
    chk("drain1_ready", o_wb_ready, 0);
    @(negedge clk);
    #1;
    chk("drain2_en", o_wb_wr_reg_en, 1);
    chk("drain2_addr", o_wb_wr_reg_addr, 2);
    chk("drain2_data", o_wb_wr_reg_data, 32'h22);
    chk("drain2_ready", o_wb_ready, 1);
    @(negedge clk);
    #1;
    chk("empty_en", o_wb_wr_reg_en, 0);
    chk("empty_data", o_wb_wr_reg_data, 0);

    // x0 write with staller
    @(negedge clk);
    set_alu(5'd0, 32'h55, 1'b1);
    @(negedge clk);
    i_valid   = 1'b0;
    i_staller = 1'b0;
    #1;
    chk("x0_en", o_wb_wr_reg_en, 0);
    chk("x0_data", o_wb_wr_reg_data, 32'h55);
    chk("x0_unstall_pre", o_unstall, 0);
    @(negedge clk);
    #1;
    chk("x0_unstall", o_unstall, 1);
    chk("x0_popped_ready", o_wb_ready, 1);
    @(negedge clk);
    #1;
    chk("x0_unstall_off", o_unstall, 0);

    // streaming: two queued, then push+pop each cycle with grant high
    np = 0; nw = 0; cnt = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      i_rf_grant = (k >= 2);
      set_alu(5'(np + 1), 32'(32'h200 + np), 1'b0);
      #1;
      if (k >= 2) begin
        chk("strm_ready", o_wb_ready, (cnt < 2) ? 1 : 0);
        chk("strm_en", o_wb_wr_reg_en, 1);
        chk("strm_addr", o_wb_wr_reg_addr, 64'(nw + 1));
        chk("strm_data", o_wb_wr_reg_data, 64'(32'h200 + nw));
      end
      pushing = (cnt < 2);
      popping = (cnt != 0) && i_rf_grant;
      if (pushing) np++;
      if (popping) nw++;
      cnt = cnt + (pushing ? 1 : 0) - (popping ? 1 : 0);
    end

    // reset mid-stream
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_en", o_wb_wr_reg_en, 0);
    chk("mrst_ready", o_wb_ready, 1);
    chk("mrst_addr", o_wb_wr_reg_addr, 0);
    chk("mrst_data", o_wb_wr_reg_data, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("mrst_hold_en", o_wb_wr_reg_en, 0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("mrst_rel_en", o_wb_wr_reg_en, 0);
    chk("mrst_rel_addr", o_wb_wr_reg_addr, 0);
    @(negedge clk);
    #1;
    chk("mrst_after_en", o_wb_wr_reg_en, 0);
    chk("mrst_after_unstall", o_unstall, 0);

`ifdef WB_FWD_EN
    @(negedge clk);
    i_rf_grant = 1'b0;
    set_alu(5'd7, 32'hA, 1'b0);
    @(negedge clk);
    set_alu(5'd7, 32'hB, 1'b0);
    @(negedge clk);
    i_valid    = 1'b0;
    i_fwd_addr = 5'd7;
    #1;
    chk("fwd7_hit", o_fwd_hit, 1);
    chk("fwd7_data", o_fwd_data, 32'hB);
    i_fwd_addr = 5'd0;
    #1;
    chk("fwd0_hit", o_fwd_hit, 0);
    chk("fwd0_data", o_fwd_data, 0);
    i_fwd_addr = 5'd3;
    #1;
    chk("fwd3_hit", o_fwd_hit, 0);
    i_fwd_addr = 5'd7;
    @(negedge clk);
    i_rf_grant = 1'b1;
    @(negedge clk);
    #1;
    chk("fwd_one_left_data", o_fwd_data, 32'hB);
    @(negedge clk);
    #1;
    chk("fwd_drained_hit", o_fwd_hit, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
